leaf_out_arbiter: RTL and testbench
===================================

# leaf_out_arbiter

Round-robin, credit-gated arbiter that shares the single leaf-interface output path among `NUM_OUT_PORTS` HLS output streams using the `ap_vld`/`ap_ack` handshake. It sits between the operator's `Output_k_V_V` ports and the leaf interface packetizer. Each cycle it grants one eligible stream, registers the word with its port index, and consumes one per-port credit. The interface returns credits as downstream freespace updates arrive.

## Interface
- `NUM_OUT_PORTS`, 4: number of user output streams.
- `PAYLOAD_BITS`, 32: width of a data word.
- `NUM_PORT_BITS`, 4: width of the port tag on the output.
- `CREDIT_BITS`, 8: width of each per-port credit counter.
- `INIT_CREDIT`, 64: credits per port after reset; also the saturation ceiling.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `din_leaf_user2interface`  in  NUM_OUT_PORTS*PAYLOAD_BITS  concatenated user words; port k is at slice [k*PAYLOAD_BITS +: PAYLOAD_BITS].
- `vld_user2interface`  in  NUM_OUT_PORTS  per-port valid.
- `ack_interface2user`  out  NUM_OUT_PORTS  per-port ack; combinational, one-hot or zero.
- `dout_payload`  out  PAYLOAD_BITS  registered granted word.
- `dout_port`  out  NUM_PORT_BITS  index of the granted port.
- `dout_vld`  out  1  output register holds a word.
- `dout_rdy`  in  1  downstream accepts; a transfer occurs when `dout_vld && dout_rdy`.
- `credit_vld`  in  1  credit return strobe.
- `credit_port`  in  NUM_PORT_BITS  port receiving the credits.
- `credit_cnt`  in  CREDIT_BITS  number of credits returned.

## Operation
- Eligibility: port k is eligible when `vld_user2interface[k]` is high and `credit[k]` is non-zero.
- Slot free: the output register can load this cycle when `!dout_vld || dout_rdy`.
- Grant: when the slot is free and at least one port is eligible, pick the first eligible port in circular order starting at `rr_ptr`.
  - Drive `ack_interface2user[g]` high in the same cycle as the grant.
  - On the next edge: load `dout_payload`, set `dout_port <= g`, set `dout_vld <= 1`, and decrement `credit[g]`.
  - Set `rr_ptr <= (g+1) mod NUM_OUT_PORTS`.
- No grant: if there is no eligible port and the downstream takes the word, set `dout_vld <= 0`.
- Two-state FSM:
  - EMPTY → FULL on grant.
  - FULL → FULL on grant while draining, or while holding.
  - FULL → EMPTY on drain without grant.
- Credit return: `credit[credit_port] += credit_cnt`, saturating at `INIT_CREDIT`.
  - Ignore `credit_port >= NUM_OUT_PORTS`.
  - If a grant and a return hit the same port in the same cycle, the result is min(credit − 1 + cnt, INIT_CREDIT).
- Ack is never asserted to a port whose credit is 0, or while the slot is not free.
- Stall: while `dout_vld && !dout_rdy`, hold `dout_payload` and `dout_port` stable.
- Reset:
  - `dout_vld`, `dout_payload` and `dout_port` go to 0, and `ack_interface2user` is 0.
  - All credits go to `INIT_CREDIT` and `rr_ptr` goes to 0.
  - A word held in the register when reset is asserted is discarded.

## Timing
- Latency: 1 cycle from ack to `dout_vld`.
- Throughput: 1 word per cycle with `dout_rdy` tied high, including back-to-back grants to the same port when it is the only eligible port.
- Credit returns take effect at the next edge, so a port at 0 credits is eligible on the cycle after the return.
- Fairness: with all ports eligible, grants cycle through 0,1,2,3,0,…; no port waits more than NUM_OUT_PORTS−1 grants.

## Structure
- Shared package `leaf_pkg`: `PAYLOAD_BITS`, `NUM_PORT_BITS` and the credit-width constants, also used by the leaf interface.
- One sub-module, `rr_pick`: combinational circular priority encoder. Inputs are the request vector and `rr_ptr`; outputs are the grant index and `any`.
- Credit counters and the output register stay in `leaf_out_arbiter`.

## Test plan
- Reset, then all 4 ports valid with data 0xA0+k and `dout_rdy=1` → outputs in port order 0,1,2,3,0… from cycle 1 after the first ack; `dout_vld` is continuous.
- Port 2 alone, INIT_CREDIT=4, no returns → exactly 4 words out tagged port 2; `ack[2]` then stays 0. Returning cnt=2 on port 2 yields 2 more words starting the cycle after the return.
- `dout_rdy=0` for 5 cycles with the register full → `dout_payload` and `dout_port` are stable, all acks are 0. `dout_rdy=1` → drain and regrant in the same cycle.
- Simultaneous grant and return of cnt=1 on port 0 at credit 64 → credit stays 64 (saturated). Return to port 9 → no counter changes.
- Reset asserted while FULL with port 1's word held → next cycle `dout_vld=0`, credits 64, the next grant goes to port 0 if port 0 is valid.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared leaf-interface constants and types for the output arbiter and packetizer.
package leaf_pkg;

   localparam int unsigned PAYLOAD_BITS      = 32;
   localparam int unsigned NUM_PORT_BITS     = 4;
   localparam int unsigned CREDIT_BITS       = 8;
   localparam int unsigned DEF_NUM_OUT_PORTS = 4;
   localparam int unsigned DEF_INIT_CREDIT   = 64;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   // Width of an index into n items, never narrower than one bit.
   function automatic int unsigned ptr_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request at or after ptr, wrapping.
module rr_pick
   import leaf_pkg::*;
#(
   parameter int unsigned N     = DEF_NUM_OUT_PORTS,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   int unsigned cand;

   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= N) cand = cand - N;
         if (!any && req[PTR_W'(cand)]) begin
            any = 1'b1;
            idx = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated arbiter sharing the leaf output register among HLS output streams.
module leaf_out_arbiter
   import leaf_pkg::*;
#(
   parameter int unsigned NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
   parameter int unsigned INIT_CREDIT   = DEF_INIT_CREDIT
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   output logic [PAYLOAD_BITS-1:0]               dout_payload,
   output logic [NUM_PORT_BITS-1:0]              dout_port,
   output logic                                  dout_vld,
   input  logic                                  dout_rdy,
   input  logic                                  credit_vld,
   input  logic [NUM_PORT_BITS-1:0]              credit_port,
   input  logic [CREDIT_BITS-1:0]                credit_cnt
);

   localparam int unsigned PTR_W = ptr_bits(NUM_OUT_PORTS);
   localparam int unsigned SUM_W = CREDIT_BITS + 1;

   out_state_e                                  state_q;
   logic [PTR_W-1:0]                            rr_ptr_q;
   logic [PTR_W-1:0]                            grant_idx;
   logic [PTR_W-1:0]                            ptr_next;
   logic                                        pick_any;
   logic                                        grant;
   logic                                        slot_free;
   logic [NUM_OUT_PORTS-1:0]                    eligible;
   logic [NUM_OUT_PORTS-1:0]                    req;
   logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   credit_q;
   logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   credit_d;
   logic [PAYLOAD_BITS-1:0]                     payload_sel;
   logic [SUM_W-1:0]                            sum;

   assign dout_vld  = (state_q == OUT_FULL);
   assign slot_free = !dout_vld || dout_rdy;

   // A port may only compete when it has data, credit, and the register can load.
   always_comb begin
      eligible = '0;
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
         eligible[k] = vld_user2interface[k] && (credit_q[k] != '0);
      end
      req = slot_free ? eligible : '0;
   end

   rr_pick #(
      .N     (NUM_OUT_PORTS),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req (req),
      .ptr (rr_ptr_q),
      .idx (grant_idx),
      .any (pick_any)
   );

   // Reset suppresses the grant so no word is acked that the register would then drop.
   assign grant    = pick_any && !reset;
   assign ptr_next = (grant_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);

   always_comb begin
      ack_interface2user = '0;
      payload_sel        = '0;
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
         if (grant_idx == PTR_W'(k)) begin
            payload_sel           = din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS];
            ack_interface2user[k] = grant;
         end
      end
   end

   // Grant consumes one credit, a return adds credits, result clamps at the initial level.
   always_comb begin
      credit_d = credit_q;
      sum      = '0;
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
         sum = SUM_W'(credit_q[k]);
         if (ack_interface2user[k]) sum = sum - SUM_W'(1);
         if (credit_vld && (credit_port == NUM_PORT_BITS'(k))) sum = sum + SUM_W'(credit_cnt);
         if (sum > SUM_W'(INIT_CREDIT)) sum = SUM_W'(INIT_CREDIT);
         credit_d[k] = sum[CREDIT_BITS-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= OUT_EMPTY;
         dout_payload <= '0;
         dout_port    <= '0;
         rr_ptr_q     <= '0;
         for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
            credit_q[k] <= CREDIT_BITS'(INIT_CREDIT);
         end
      end else begin
         case (state_q)
            OUT_EMPTY: if (grant) state_q <= OUT_FULL;
            OUT_FULL:  if (!grant && dout_rdy) state_q <= OUT_EMPTY;
            default:   state_q <= OUT_EMPTY;
         endcase
         if (grant) begin
            dout_payload <= payload_sel;
            dout_port    <= NUM_PORT_BITS'(grant_idx);
            rr_ptr_q     <= ptr_next;
         end
         credit_q <= credit_d;
      end
   end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: table of per-cycle vectors plus credit-exhaustion sequences.
module tb_leaf_out_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [127:0] din;

   logic [3:0]   vld = '0;
   logic         rdy = 1'b0;
   logic         cv = 1'b0;
   logic [3:0]   cp = '0;
   logic [7:0]   cc = '0;
   logic [3:0]   ack;
   logic [31:0]  pay;
   logic [3:0]   port;
   logic         ovld;

   logic [3:0]   s_vld = '0;
   logic         s_rdy = 1'b1;
   logic         s_cv = 1'b0;
   logic [3:0]   s_cp = '0;
   logic [7:0]   s_cc = '0;
   logic [3:0]   s_ack;
   logic [31:0]  s_pay;
   logic [3:0]   s_port;
   logic         s_ovld;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   leaf_out_arbiter dut (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_user2interface (din),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .dout_payload            (pay),
      .dout_port               (port),
      .dout_vld                (ovld),
      .dout_rdy                (rdy),
      .credit_vld              (cv),
      .credit_port             (cp),
      .credit_cnt              (cc)
   );

   leaf_out_arbiter #(.NUM_OUT_PORTS(4), .INIT_CREDIT(4)) dut_s (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_user2interface (din),
      .vld_user2interface      (s_vld),
      .ack_interface2user      (s_ack),
      .dout_payload            (s_pay),
      .dout_port               (s_port),
      .dout_vld                (s_ovld),
      .dout_rdy                (s_rdy),
      .credit_vld              (s_cv),
      .credit_port             (s_cp),
      .credit_cnt              (s_cc)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic        rdy;
      logic        cv;
      logic [3:0]  cp;
      logic [7:0]  cc;
      logic [3:0]  e_ack;
      logic        e_vld;
      logic [3:0]  e_port;
      logic [31:0] e_pay;
      logic        chk_d;
      logic [7:0]  e_c0;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) din[k*32 +: 32] = 32'h000000A0 + 32'(k);

      //           rst vld    rdy cv cp    cc     ack    vld port  payload      chk c0
      tbl[0]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0001, 1'b0, 4'd0, 32'h00, 1'b1, 8'd64};
      tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0010, 1'b1, 4'd0, 32'hA0, 1'b1, 8'd63};
      tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0100, 1'b1, 4'd1, 32'hA1, 1'b1, 8'd63};
      tbl[3]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b1000, 1'b1, 4'd2, 32'hA2, 1'b1, 8'd63};
      tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0001, 1'b1, 4'd3, 32'hA3, 1'b1, 8'd63};
      for (int i = 5; i < 10; i++)
         tbl[i] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b1, 4'd0, 32'hA0, 1'b1, 8'd62};
      tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0010, 1'b1, 4'd0, 32'hA0, 1'b1, 8'd62};
      tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b1, 4'd1, 32'hA1, 1'b1, 8'd62};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b0, 4'd0, 32'h00, 1'b0, 8'd62};
      tbl[13] = '{1'b0, 4'h2, 1'b0, 1'b0, 4'd0, 8'd0, 4'b0010, 1'b0, 4'd0, 32'h00, 1'b0, 8'd62};
      tbl[14] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b1, 4'd1, 32'hA1, 1'b1, 8'd62};
      tbl[15] = '{1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b1, 4'd1, 32'hA1, 1'b1, 8'd62};
      tbl[16] = '{1'b0, 4'hF, 1'b1, 1'b1, 4'd0, 8'd1, 4'b0001, 1'b0, 4'd0, 32'h00, 1'b1, 8'd64};
      tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'd9, 8'd5, 4'b0000, 1'b1, 4'd0, 32'hA0, 1'b1, 8'd64};
      tbl[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 8'd0, 4'b0000, 1'b0, 4'd0, 32'h00, 1'b0, 8'd64};

      step();
      step();
      for (int i = 0; i < 19; i++) begin
         step();
         reset = tbl[i].rst;
         vld   = tbl[i].vld;
         rdy   = tbl[i].rdy;
         cv    = tbl[i].cv;
         cp    = tbl[i].cp;
         cc    = tbl[i].cc;
         @(negedge clk);
         chk($sformatf("row%0d ack", i), 64'(ack), 64'(tbl[i].e_ack));
         chk($sformatf("row%0d vld", i), 64'(ovld), 64'(tbl[i].e_vld));
         chk($sformatf("row%0d credit0", i), 64'(dut.credit_q[0]), 64'(tbl[i].e_c0));
         if (tbl[i].chk_d) begin
            chk($sformatf("row%0d port", i), 64'(port), 64'(tbl[i].e_port));
            chk($sformatf("row%0d payload", i), 64'(pay), 64'(tbl[i].e_pay));
         end
      end
      for (int k = 1; k < 4; k++)
         chk($sformatf("credit%0d after bad-port return", k), 64'(dut.credit_q[k]), 64'd64);

      // Port 2 alone on the 4-credit instance: four words, then starved.
      vld = '0;
      cv  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         s_vld = 4'b0100;
         @(negedge clk);
         chk($sformatf("solo c%0d ack", i), 64'(s_ack), (i < 4) ? 64'h4 : 64'h0);
         chk($sformatf("solo c%0d vld", i), 64'(s_ovld), (i >= 1 && i <= 4) ? 64'h1 : 64'h0);
         if (i >= 1 && i <= 4) begin
            chk($sformatf("solo c%0d port", i), 64'(s_port), 64'd2);
            chk($sformatf("solo c%0d payload", i), 64'(s_pay), 64'hA2);
         end
      end

      // Return two credits: acks resume the cycle after the return.
      step();
      s_cv = 1'b1; s_cp = 4'd2; s_cc = 8'd2;
      @(negedge clk);
      chk("ret cycle ack", 64'(s_ack), 64'h0);
      step();
      s_cv = 1'b0;
      @(negedge clk);
      chk("ret+1 ack", 64'(s_ack), 64'h4);
      chk("ret+1 vld", 64'(s_ovld), 64'h0);
      step();
      @(negedge clk);
      chk("ret+2 ack", 64'(s_ack), 64'h4);
      chk("ret+2 vld", 64'(s_ovld), 64'h1);
      chk("ret+2 port", 64'(s_port), 64'd2);
      step();
      @(negedge clk);
      chk("ret+3 ack", 64'(s_ack), 64'h0);
      chk("ret+3 vld", 64'(s_ovld), 64'h1);
      step();
      @(negedge clk);
      chk("ret+4 vld", 64'(s_ovld), 64'h0);

      // Oversized return clamps at the initial credit level.
      step();
      s_vld = '0;
      s_cv = 1'b1; s_cp = 4'd2; s_cc = 8'd200;
      step();
      s_cv = 1'b0;
      @(negedge clk);
      chk("clamp credit2", 64'(dut_s.credit_q[2]), 64'd4);
      chk("clamp credit0", 64'(dut_s.credit_q[0]), 64'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
